// File: rtl/jk_ff.sv
// Bank of independent rising-edge JK flip-flops with complementary outputs.
// q and qb both come from a single state register, so they can never disagree.
module jk_ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] next_s;

    // Per bit: j sets a cleared bit, and a set bit survives only while k is low.
    // This covers hold, set, reset and toggle in one expression.
    function automatic logic [WIDTH-1:0] jk_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] j_v,
        input logic [WIDTH-1:0] k_v
    );
        return (j_v & ~cur) | (~k_v & cur);
    endfunction

    // Next-state decode for all bits
    always_comb begin
        next_s = jk_next(state_r, j, k);
    end

    // State register with asynchronous reset to RST_VAL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RST_VAL;
        end else begin
            state_r <= next_s;
        end
    end

    assign q  = state_r;
    assign qb = ~state_r;

endmodule

// File: tb/tb_jk_ff.sv
// Self-checking bench for jk_ff: directed vector table, reset corner cases,
// and randomized j/k/reset traffic against a per-bit behavioural model.
module tb_jk_ff;

    logic       clk;
    logic       rst;
    logic       j1, k1;
    logic       q1, qb1;
    logic [3:0] j4, k4;
    logic [3:0] q4, qb4;

    int total = 0;
    int bad   = 0;

    jk_ff #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .j(j1), .k(k1), .q(q1), .qb(qb1)
    );

    jk_ff #(.WIDTH(4), .RST_VAL(4'b1010)) dut4 (
        .clk(clk), .rst(rst), .j(j4), .k(k4), .q(q4), .qb(qb4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic j;
        logic k;
        logic q;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Behavioural JK rule from the truth table
    function automatic int jk_model(input int cur, input int jv, input int kv);
        if (jv == 0 && kv == 0) return cur;
        if (jv == 0)            return 0;
        if (kv == 0)            return 1;
        return 1 - cur;
    endfunction

    int m1;
    int m4 [4];
    int rst_val4 [4] = '{0, 1, 0, 1};   // index = bit number of 4'b1010

    function automatic logic [3:0] pack4(input int b [4]);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (b[i] != 0);
        return r;
    endfunction

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        j1 = 1'b0; k1 = 1'b0;
        j4 = 4'b0000; k4 = 4'b0000;

        // Reset is visible before any clock edge
        #1;
        check("reset_q1",  {3'b000, q1},  4'b0000);
        check("reset_qb1", {3'b000, qb1}, 4'b0001);
        check("reset_q4",  q4,  4'b1010);
        check("reset_qb4", qb4, 4'b0101);

        @(negedge clk);
        rst = 1'b0;

        // Directed table: hold, set, hold, reset, hold, toggle
        for (int i = 0; i < 10; i++) begin
            j1 = tbl[i].j;
            k1 = tbl[i].k;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_q", i),  {3'b000, q1},  {3'b000, tbl[i].q});
            check($sformatf("vec%0d_qb", i), {3'b000, qb1}, {3'b000, ~tbl[i].q});
            @(negedge clk);
        end

        // Asynchronous reset mid-toggle, edges ignored while asserted
        #2;
        rst = 1'b1;
        #1;
        check("midtoggle_rst_q",  {3'b000, q1},  4'b0000);
        check("midtoggle_rst_qb", {3'b000, qb1}, 4'b0001);
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d_q", e), {3'b000, q1}, 4'b0000);
            check($sformatf("rst_hold%0d_q4", e), q4, 4'b1010);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_toggle_q",  {3'b000, q1},  4'b0001);
        check("post_rst_toggle_qb", {3'b000, qb1}, 4'b0000);

        // Wide bank: bit0 toggle, bit1 set, bit2 reset, bit3 hold
        @(negedge clk);
        j1 = 1'b0; k1 = 1'b0;
        j4 = 4'b0011; k4 = 4'b0101;
        @(posedge clk);
        #1;
        check("wide_q4",  q4,  4'b1011);
        check("wide_qb4", qb4, 4'b0100);
        check("wide_hold_q1", {3'b000, q1}, 4'b0001);

        // Randomized traffic against the model, with occasional async resets
        m1 = 1;
        m4 = '{1, 1, 0, 1};
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            rst = 1'b0;
            j1 = 1'($urandom); k1 = 1'($urandom);
            j4 = 4'($urandom); k4 = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                #2;
                rst = 1'b1;
                m1 = 0;
                m4 = rst_val4;
                #1;
                check("rand_async_q1", {3'b000, q1}, 4'b0000);
                check("rand_async_q4", q4, 4'b1010);
            end
            @(posedge clk);
            if (!rst) begin
                m1 = jk_model(m1, int'(j1), int'(k1));
                for (int b = 0; b < 4; b++)
                    m4[b] = jk_model(m4[b], int'(j4[b]), int'(k4[b]));
            end
            #1;
            check("rand_q1",  {3'b000, q1},  {3'b000, (m1 != 0)});
            check("rand_qb1", {3'b000, qb1}, {3'b000, (m1 == 0)});
            check("rand_q4",  q4,  pack4(m4));
            check("rand_qb4", qb4, ~pack4(m4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
